// File: rtl/sw_press_conditioner.sv
// Switch input conditioner: two-flop synchronizer, per-channel debounce and
// one-hot press qualification feeding the switch-driven state machine.
module sw_press_conditioner #(
    parameter int NUM_SW          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int PULSE_MODE      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_out,
    output logic [NUM_SW-1:0] sw_level,
    output logic              conflict
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic int unsigned popcount(input logic [NUM_SW-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    logic [NUM_SW-1:0] sync1_p0;
    logic [NUM_SW-1:0] sync2_p1;
    logic [NUM_SW-1:0] db_p2;
    logic [CNT_W-1:0]  cnt_p2 [NUM_SW];

    logic [NUM_SW-1:0] next_db;
    logic [CNT_W-1:0]  next_cnt [NUM_SW];
    logic [NUM_SW-1:0] rise;
    logic              single;

    // Stage p0/p1: metastability synchronizer, nothing between the flops
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
        end else begin
            sync1_p0 <= sw_raw;
            sync2_p1 <= sync1_p0;
        end
    end

    // A bounce back to agreement restarts the count; cnt never passes CNT_LAST
    always_comb begin
        next_db = db_p2;
        for (int i = 0; i < NUM_SW; i++) begin
            next_cnt[i] = '0;
            if (sync2_p1[i] != db_p2[i]) begin
                if (cnt_p2[i] == CNT_LAST) begin
                    next_db[i] = sync2_p1[i];
                end else begin
                    next_cnt[i] = cnt_p2[i] + CNT_W'(1);
                end
            end
        end
    end

    // Stage p2: debounced level and per-channel counters
    always_ff @(posedge clk) begin
        if (reset) begin
            db_p2 <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_p2[i] <= '0;
            end
        end else begin
            db_p2 <= next_db;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_p2[i] <= next_cnt[i];
            end
        end
    end

    // Qualify on the value db is about to take so the pulse lines up with the level
    always_comb begin
        rise   = next_db & ~db_p2;
        single = (popcount(next_db) == 1);
    end

    assign sw_level = db_p2;
    assign conflict = (popcount(db_p2) >= 2);

    generate
        if (PULSE_MODE != 0) begin : g_pulse
            logic [NUM_SW-1:0] pulse_p3;

            // Stage p3: one-cycle press pulse, only for a lone rising switch
            always_ff @(posedge clk) begin
                if (reset) begin
                    pulse_p3 <= '0;
                end else begin
                    pulse_p3 <= rise & {NUM_SW{single}};
                end
            end

            assign sw_out = pulse_p3;
        end else begin : g_level
            assign sw_out = (popcount(db_p2) == 1) ? db_p2 : '0;
        end
    endgenerate

endmodule

// File: doc/sw_press_conditioner.md
Name: sw_press_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the lab switch-driven state machine.
- Takes raw, asynchronous, bouncing board switches, then synchronizes and debounces them per switch.
- Qualifies presses as one-hot and delivers clean single-cycle press pulses, or qualified levels, to the FSM's SW inputs.
- Prevents the downstream FSM from advancing on every clock while a switch is held, and from taking a transition when two switches are pressed together.

Parameters:
- NUM_SW, 4: number of switch channels.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized value must differ from the debounced value before it is accepted. Legal range 1 to 2^CNT_W-1.
- CNT_W, 4: width of each per-channel debounce counter.
- PULSE_MODE, 1: 1 makes sw_out a one-cycle press pulse; 0 makes sw_out the one-hot-qualified debounced level.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- sw_raw, input, NUM_SW: raw switch inputs; asynchronous to clk and may bounce.
- sw_out, output, NUM_SW: conditioned switch vector to the downstream FSM. Zero or one-hot, never multi-hot.
- sw_level, output, NUM_SW: debounced level of each switch, unqualified.
- conflict, output, 1: high while two or more debounced switches are high.

Behaviour:
- Reset (sampled on a clk rising edge while reset=1):
  - sync1, sync2, the debounced register db, all counters and the pulse register clear to 0.
  - Therefore sw_out=0, sw_level=0 and conflict=0 on the cycle after the reset edge.
  - Reset has priority over all other activity.
- Synchronizer: each channel uses 2 flops (sync1 <= sw_raw; sync2 <= sync1). No logic between the two flops.
- Debounce, per channel i, each edge:
  - If sync2[i]==db[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: db[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any return to agreement, i.e. a bounce, restarts the count from 0.
- Latency: a clean sw_raw change set up before edge E appears on sw_level after edge E+DEBOUNCE_CYCLES+1. With the default of 4, that is the 6th edge counting E as the first.
- sw_level = db (registered). conflict = (popcount(db) >= 2), combinational from db.
- Qualification uses next_db, the value db takes on the current edge:
  - rise[i] = next_db[i] & ~db[i].
  - single = (popcount(next_db)==1).
- PULSE_MODE=1:
  - sw_out is registered: sw_out <= rise & {NUM_SW{single}}.
  - A pulse is asserted on the same edge that db rises and lasts exactly one cycle.
  - A held switch produces no further pulses.
  - Falling edges never pulse.
  - A rise while another switch is already debounced-high produces no pulse.
  - Two rises on the same edge produce no pulse.
- PULSE_MODE=0: sw_out = db when popcount(db)==1, else 0 (combinational from db).
- Releasing all but one switch:
  - Level mode: sw_out shows the remaining switch.
  - Pulse mode: no pulse is generated for the remaining switch.
- Reset mid-count: any partial count is discarded.
- Switch held through reset release: sync1 samples it on the first edge after reset deasserts. It is then treated as a new press, giving a pulse on the 6th edge after deassertion (default DEBOUNCE_CYCLES).
- Counters never wrap: cnt is bounded at DEBOUNCE_CYCLES-1.

Test Plan:
1. Clean press, default parameters: reset, then sw_raw=4'b0001 held.
   - sw_level=0001 after the 6th edge.
   - sw_out=0001 for exactly 1 cycle, coincident with the sw_level rise, then 0 while held.
   - conflict=0 throughout.
2. Bounce on sw_raw[1]: toggle every 2 cycles for 12 cycles, then hold 1.
   - sw_level[1] stays 0 through the bounce and rises 6 edges after the final 0->1 transition.
   - Exactly one sw_out=0010 pulse.
3. Overlapping presses: hold sw_raw[0] until debounced, then also press sw_raw[2].
   - No sw_out pulse for bit 2.
   - conflict=1 once sw_level=0101.
   - Release sw_raw[0]: conflict=0 once sw_level=0100, and no pulse.
4. Simultaneous press: sw_raw goes 0000->0011 on one edge.
   - sw_level=0011 on the same edge for both bits.
   - sw_out stays 0000; conflict=1.
5. Reset mid-debounce: press sw_raw[3], assert reset for 1 cycle at edge 3.
   - All outputs are 0 after the reset edge.
   - With sw_raw[3] still held, a single sw_out=1000 pulse appears on the 6th edge after reset deasserts.
6. PULSE_MODE=0: press and hold sw_raw[2].
   - sw_out=0100 continuously after debounce.
   - Adding sw_raw[0] gives sw_out=0000 and conflict=1.
   - Releasing sw_raw[0] gives sw_out=0100 again.
